// File: rtl/cnt_delta_pulse.sv
// cnt_delta_pulse: turns a synchronised free-running count into handshaked
// event strobes, a saturating backlog and a wide running total.
// Ports:
//    clk      receiving-domain clock
//    rst      asynchronous active-high reset
//    cnt_in   synchronised count sample (CW bits)
//    ev_valid at least one event pending
//    ev_ready consumer takes one event this cycle
//    pending  backlog of unconsumed events (saturates at 2^PW-1)
//    total    running sum of all increments, wraps mod 2^TW
//    ovf      sticky flag: backlog saturated and events were lost
//    clr_ovf  synchronous clear of ovf (a same-edge saturation wins)
module cnt_delta_pulse #(
   parameter int CW = 8,
   parameter int PW = 10,
   parameter int TW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] cnt_in,
   output logic          ev_valid,
   input  logic          ev_ready,
   output logic [PW-1:0] pending,
   output logic [TW-1:0] total,
   output logic          ovf,
   input  logic          clr_ovf
);
   // sum width covers pending + delta without overflow
   localparam int SW = (CW > PW ? CW : PW) + 2;
   localparam logic [SW-1:0] PMAX = {{(SW-PW){1'b0}}, {PW{1'b1}}};
   typedef enum logic {INIT, RUN} state_t;
   state_t        state_q;
   logic [CW-1:0] prev_q;
   logic [PW-1:0] pending_q;
   logic [PW-1:0] pending_d;
   logic [TW-1:0] total_q;
   logic          ovf_q;
   logic [CW-1:0] delta;
   logic [SW-1:0] sum;
   logic          pop;
   logic          sat;
   assign ev_valid = pending_q != '0;
   assign pending  = pending_q;
   assign total    = total_q;
   assign ovf      = ovf_q;
   always_comb begin
      // modular subtraction gives the correct delta across a count wrap
      delta     = cnt_in - prev_q;
      pop       = ev_valid & ev_ready;
      // pop implies pending_q >= 1, so this never underflows
      sum       = SW'(pending_q) + SW'(delta) - SW'(pop);
      sat       = sum > PMAX;
      pending_d = sat ? {PW{1'b1}} : sum[PW-1:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= INIT;
         prev_q    <= '0;
         pending_q <= '0;
         total_q   <= '0;
         ovf_q     <= 1'b0;
      end else if (state_q == INIT) begin
         prev_q  <= cnt_in;
         state_q <= RUN;
      end else begin
         prev_q    <= cnt_in;
         pending_q <= pending_d;
         total_q   <= total_q + TW'(delta);
         ovf_q     <= sat | (ovf_q & ~clr_ovf);
      end
   end
endmodule

// File: tb/tb_cnt_delta_pulse.sv
// tb_cnt_delta_pulse: scoreboard bench with a behavioural event-count model.
module tb_cnt_delta_pulse;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cnt_in = 8'h05;
   logic       ev_valid;
   logic       ev_ready = 1'b0;
   logic [9:0] pending;
   logic [31:0] total;
   logic       ovf;
   logic       clr_ovf = 1'b0;

   cnt_delta_pulse dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .ev_valid(ev_valid),
      .ev_ready(ev_ready), .pending(pending), .total(total),
      .ovf(ovf), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {int p; longint t; bit o; bit v;} exp_t;
   exp_t q[$];
   int errors = 0;
   int checks = 0;

   // model state: plain integers describing the event bookkeeping
   bit     m_init = 1'b1;
   int     m_prev = 0;
   int     m_pend = 0;
   longint m_total = 0;
   bit     m_ovf = 1'b0;

   task automatic chk(input string n, input longint a, input longint e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", n, a, e, $time);
      end
   endtask

   // called at a negedge: drive inputs, predict the next edge, wait a cycle
   task automatic step(input int c, input bit r, input bit co);
      int d, s;
      bit pop;
      exp_t e;
      cnt_in = 8'(c); ev_ready = r; clr_ovf = co;
      if (m_init) begin
         m_prev = c % 256;
         m_init = 1'b0;
      end else begin
         d = ((c % 256) - m_prev + 256) % 256;
         pop = (m_pend != 0) && r;
         s = m_pend + d - int'(pop);
         if (s > 1023) begin
            m_pend = 1023;
            m_ovf = 1'b1;
         end else begin
            m_pend = s;
            if (co) m_ovf = 1'b0;
         end
         m_total = (m_total + d) % 64'h1_0000_0000;
         m_prev = c % 256;
      end
      e.p = m_pend; e.t = m_total; e.o = m_ovf; e.v = (m_pend != 0);
      q.push_back(e);
      @(negedge clk);
   endtask

   // monitor: the DUT presents a fresh state after every edge
   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("pending", longint'(pending), longint'(e.p));
         chk("total", longint'(total), e.t);
         chk("ovf", longint'(ovf), longint'(e.o));
         chk("ev_valid", longint'(ev_valid), longint'(e.v));
      end
   end

   initial begin
      int c;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pending", longint'(pending), 0);
      chk("rst_valid", longint'(ev_valid), 0);
      rst = 1'b0;
      // baseline
      step(5, 0, 0);
      repeat (3) step(5, 1, 0);
      chk("base_total", longint'(total), 0);
      // burst of three
      step(8, 1, 0);
      chk("burst_pending", longint'(pending), 3);
      repeat (4) step(8, 1, 0);
      chk("burst_total", longint'(total), 3);
      // wrap through zero
      step(8'hFE, 0, 0);
      step(8'h03, 0, 0);
      chk("wrap_pending", longint'(pending), 251);
      repeat (260) step(3, 1, 0);
      // backpressure and saturation
      c = 3;
      repeat (4) begin c = (c + 200) % 256; step(c, 0, 0); end
      chk("bp_pending", longint'(pending), 800);
      chk("bp_ovf", longint'(ovf), 0);
      c = (c + 255) % 256; step(c, 0, 0);
      chk("sat_pending", longint'(pending), 1023);
      chk("sat_ovf", longint'(ovf), 1);
      step(c, 0, 1);
      chk("clr_ovf", longint'(ovf), 0);
      c = (c + 5) % 256; step(c, 0, 1);
      chk("set_wins", longint'(ovf), 1);
      // drain to one, then simultaneous pop and delta
      repeat (1022) step(c, 1, 0);
      chk("drain_pending", longint'(pending), 1);
      c = (c + 2) % 256; step(c, 1, 0);
      chk("simul_pending", longint'(pending), 2);
      // async reset mid-cycle with backlog
      c = (c + 38) % 256; step(c, 0, 0);
      chk("pre_rst_pending", longint'(pending), 40);
      #2 rst = 1'b1;
      #1;
      chk("arst_pending", longint'(pending), 0);
      chk("arst_valid", longint'(ev_valid), 0);
      chk("arst_total", longint'(total), 0);
      chk("arst_ovf", longint'(ovf), 0);
      m_init = 1'b1; m_pend = 0; m_total = 0; m_ovf = 1'b0; m_prev = 0;
      cnt_in = 8'd77;
      @(negedge clk);
      rst = 1'b0;
      step(77, 1, 0);
      step(77, 1, 0);
      chk("post_rst_valid", longint'(ev_valid), 0);
      // randomized traffic
      c = 77;
      repeat (400) begin
         c = (c + (($urandom_range(0, 15) == 0) ? $urandom_range(0, 255)
                                               : $urandom_range(0, 3))) % 256;
         step(c, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      end
      repeat (2) @(negedge clk);
      chk("queue_drained", longint'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cnt_delta_pulse.md
Name: cnt_delta_pulse

Overview:
- Downstream stage of the cross-clock counter. Sits in the receiving clock domain and consumes the synchronised count value.
- Each cycle it computes the wrap-aware difference between consecutive count samples.
- It regenerates one handshaked event strobe per counted increment and keeps a wide running total, so consumers in the receiving domain need not interpret raw count values.

Parameters:
CW, 8, width of incoming synchronised count.
PW, 10, width of pending-event counter (backlog capacity 2^PW-1).
TW, 32, width of running total.

Ports:
clk  input  1  receiving-domain clock; single clock for the whole block.
rst  input  1  asynchronous, active-high reset.
cnt_in  input  CW  synchronised count, already in clk domain, changes only on clk edges.
ev_valid  output  1  at least one event pending.
ev_ready  input  1  consumer accepts one event this cycle.
pending  output  PW  current backlog of unconsumed events.
total  output  TW  running sum of all counted increments since reset, wraps mod 2^TW.
ovf  output  1  sticky: backlog saturated and events were lost.
clr_ovf  input  1  synchronous clear of ovf.

Behaviour:
- Reset (async assert, any time): state INIT; prev=0, pending=0, total=0, ovf=0, ev_valid=0. Reset mid-operation discards the backlog immediately.
- States:
  - INIT: on the first clk edge after reset release, prev<=cnt_in, then go to RUN. Nothing is counted at this edge, so cnt_in at release is the baseline.
  - RUN: remains in RUN until reset.
- RUN, per edge:
  - delta = (cnt_in - prev) mod 2^CW, as a CW-bit unsigned value.
  - prev<=cnt_in.
  - pop = ev_valid & ev_ready.
  - sum = pending + delta - pop, computed at PW+1 bits or wider.
  - If sum > 2^PW-1: pending<=2^PW-1 and ovf<=1. Otherwise pending<=sum.
  - total<=total+delta (mod 2^TW). total is not affected by saturation.
- ev_valid = (pending != 0), derived from the registered pending value. No combinational path from ev_ready or cnt_in to any output.
- Latency: a cnt_in change sampled at edge k is reflected in pending, total and ev_valid in the cycle after edge k.
- Handshake:
  - An event transfers on each edge with ev_valid & ev_ready.
  - At most one event transfers per cycle.
  - ev_ready while ev_valid=0 has no effect.
- Simultaneous delta and pop: both are applied in the same edge (net delta-1). A pop with pending=1 and delta=0 drives pending to 0.
- Wrap-around: a count wrapping from 2^CW-1 through 0 yields the correct modular delta.
- Aliasing limit: the upstream must produce fewer than 2^CW increments between consecutive clk samples. Violations alias silently and are not detected.
- ovf: set on saturation. clr_ovf clears it. If saturation and clr_ovf occur on the same edge, set wins.
- In INIT, ev_ready, clr_ovf and cnt_in changes are ignored, except that cnt_in is captured as the baseline.

Test Plan:
1. Baseline: cnt_in=0x05 held through reset release → after INIT, pending=0, total=0, ev_valid=0 indefinitely.
2. Burst: from baseline 0x05, cnt_in=0x08 with ev_ready=1 → pending=3 one cycle later; ev_valid high for exactly 3 consecutive cycles; total=3.
3. Wrap: prev=0xFE, cnt_in=0x03, ev_ready=0 → pending +5, total +5.
4. Backpressure and saturation: ev_ready=0, cnt_in advances by 200 four times → pending=800, ovf=0. A further advance of 255 → pending=1023, ovf=1, total=1055. Pulse clr_ovf → ovf=0. The same edge with saturation and clr_ovf → ovf=1.
5. Simultaneous: pending=1, ev_ready=1, delta=2 on the same edge → pending=2 and the event transfers.
6. Async reset with pending=40 and ev_valid=1, asserted mid-cycle → outputs go to 0 without waiting for a clk edge. After release, the new cnt_in is the baseline and no stale events appear.
